climate_ctrl: RTL and testbench

Multi-channel climate controller for the cold-storage design. It takes temperature/humidity samples from `N_CH` sensor readers (DHT11-class, one `sample_valid` strobe per channel) and aggregates the worst case across healthy channels: hottest temperature and driest humidity. It drives the cooling-fan and humidifier enables through hysteresis state machines with a minimum dwell time. It also flags stale sensors and forces a fail-safe actuator state when every channel has failed. It sits between the sensor readers and the LED/UART/LCD consumers, replacing the single-sensor, threshold-only fan/humidifier logic.

---
 rtl/climate_pkg.sv | 24 ++
 rtl/climate_ctrl_channel_monitor.sv | 63 ++++++
 rtl/climate_ctrl.sv | 159 +++++++++++++++
 tb/tb_climate_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/climate_pkg.sv
// Shared types and threshold helpers for the climate controller.
// Thresholds are carried as 32-bit values saturated to a caller-chosen width.
package climate_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } act_state_t;

  localparam int HYST_DEFAULT = 2;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/climate_ctrl_channel_monitor.sv
// One sensor channel: latches the last sample, remembers it was ever seen,
// and flags the channel stale when no strobe arrives for STALE_CYC cycles.
module channel_monitor
  import climate_pkg::*;
#(
  parameter int DW        = 8,
  parameter int STALE_CYC = 300_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] temp_in,
  input  logic [DW-1:0] hum_in,
  output logic [DW-1:0] temp_out,
  output logic [DW-1:0] hum_out,
  output logic          seen,
  output logic          fault
);

  localparam int SCW = $clog2(STALE_CYC + 1);
  localparam logic [SCW-1:0] STALE_MAX = SCW'(STALE_CYC);

  logic [DW-1:0]  temp_q, temp_d;
  logic [DW-1:0]  hum_q, hum_d;
  logic           seen_q, seen_d;
  logic [SCW-1:0] cnt_q, cnt_d;

  // A strobe always clears the counter, so it wins over the edge that would hit the limit.
  always_comb begin
    temp_d = temp_q;
    hum_d  = hum_q;
    seen_d = seen_q;
    cnt_d  = cnt_q;
    if (sample_valid) begin
      temp_d = temp_in;
      hum_d  = hum_in;
      seen_d = 1'b1;
      cnt_d  = '0;
    end else if (cnt_q != STALE_MAX) begin
      cnt_d = cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      temp_q <= '0;
      hum_q  <= '0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      temp_q <= temp_d;
      hum_q  <= hum_d;
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

  assign temp_out = temp_q;
  assign hum_out  = hum_q;
  assign seen     = seen_q;
  assign fault    = (cnt_q == STALE_MAX);

endmodule

// File: rtl/climate_ctrl.sv
// Worst-case aggregation over healthy sensor channels driving fan and
// humidifier hysteresis FSMs with minimum dwell and an all-stale fail-safe.
module climate_ctrl
  import climate_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DW        = 8,
  parameter int HYST      = HYST_DEFAULT,
  parameter int DWELL_CYC = 1_000_000,
  parameter int STALE_CYC = 300_000_000
) (
  input  logic               clk,
  input  logic               rst_n,  // active-high asynchronous reset
  input  logic [N_CH-1:0]    sample_valid,
  input  logic [N_CH*DW-1:0] temperature,
  input  logic [N_CH*DW-1:0] humidity,
  input  logic [DW-1:0]      temp_set,
  input  logic [DW-1:0]      hum_set,
  output logic               fan_on,
  output logic               hum_on,
  output logic [N_CH-1:0]    fault,
  output logic [DW-1:0]      t_max,
  output logic [DW-1:0]      h_min,
  output logic               agg_valid
);

  localparam int DCW = $clog2(DWELL_CYC + 1);
  localparam logic [DCW-1:0] DWELL_MAX = DCW'(DWELL_CYC);

  logic [N_CH-1:0] seen, included;
  logic [DW-1:0]   ch_temp [N_CH];
  logic [DW-1:0]   ch_hum  [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    channel_monitor #(.DW(DW), .STALE_CYC(STALE_CYC)) u_mon (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_valid(sample_valid[gi]),
      .temp_in     (temperature[gi*DW +: DW]),
      .hum_in      (humidity[gi*DW +: DW]),
      .temp_out    (ch_temp[gi]),
      .hum_out     (ch_hum[gi]),
      .seen        (seen[gi]),
      .fault       (fault[gi])
    );
  end

  assign included = seen & ~fault;

  logic [DW-1:0] t_max_q, t_max_d, h_min_q, h_min_d;
  logic          agg_valid_q, agg_valid_d;
  logic [DW-1:0] t_acc, h_acc;
  logic          any_inc;

  // With nothing included the aggregates keep their last values.
  always_comb begin
    any_inc = 1'b0;
    t_acc   = '0;
    h_acc   = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (included[i]) begin
        any_inc = 1'b1;
        if (ch_temp[i] > t_acc) t_acc = ch_temp[i];
        if (ch_hum[i] < h_acc)  h_acc = ch_hum[i];
      end
    end
    agg_valid_d = any_inc;
    t_max_d     = any_inc ? t_acc : t_max_q;
    h_min_d     = any_inc ? h_acc : h_min_q;
  end

  // Thresholds live in DW+1 bits so a setpoint near full scale yields an unreachable level.
  logic [31:0] t_on_w, t_off_w, h_on_w, h_off_w, t_max_w, h_min_w;
  always_comb begin
    t_on_w  = sat_add(32'(temp_set), 32'(HYST), DW + 1);
    t_off_w = sat_sub(32'(temp_set), 32'(HYST));
    h_on_w  = sat_sub(32'(hum_set), 32'(HYST));
    h_off_w = sat_add(32'(hum_set), 32'(HYST), DW + 1);
    t_max_w = 32'(t_max_q);
    h_min_w = 32'(h_min_q);
  end

  logic       all_faulted;
  act_state_t fan_q, fan_d, hum_q, hum_d;
  logic [DCW-1:0] fan_dwell_q, fan_dwell_d, hum_dwell_q, hum_dwell_d;

  assign all_faulted = &fault;

  always_comb begin
    fan_d       = fan_q;
    fan_dwell_d = (fan_dwell_q != '0) ? fan_dwell_q - DCW'(1) : '0;
    if (all_faulted) begin
      if (fan_q != ON) begin
        fan_d       = ON;
        fan_dwell_d = DWELL_MAX;
      end
    end else if (agg_valid_q && fan_dwell_q == '0) begin
      case (fan_q)
        OFF: if (t_max_w >= t_on_w) begin
          fan_d       = ON;
          fan_dwell_d = DWELL_MAX;
        end
        ON: if (t_max_w <= t_off_w) begin
          fan_d       = OFF;
          fan_dwell_d = DWELL_MAX;
        end
      endcase
    end
  end

  always_comb begin
    hum_d       = hum_q;
    hum_dwell_d = (hum_dwell_q != '0) ? hum_dwell_q - DCW'(1) : '0;
    if (all_faulted) begin
      if (hum_q != OFF) begin
        hum_d       = OFF;
        hum_dwell_d = DWELL_MAX;
      end
    end else if (agg_valid_q && hum_dwell_q == '0) begin
      case (hum_q)
        OFF: if (h_min_w <= h_on_w) begin
          hum_d       = ON;
          hum_dwell_d = DWELL_MAX;
        end
        ON: if (h_min_w >= h_off_w) begin
          hum_d       = OFF;
          hum_dwell_d = DWELL_MAX;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      t_max_q     <= '0;
      h_min_q     <= '0;
      agg_valid_q <= 1'b0;
      fan_q       <= OFF;
      hum_q       <= OFF;
      fan_dwell_q <= '0;
      hum_dwell_q <= '0;
    end else begin
      t_max_q     <= t_max_d;
      h_min_q     <= h_min_d;
      agg_valid_q <= agg_valid_d;
      fan_q       <= fan_d;
      hum_q       <= hum_d;
      fan_dwell_q <= fan_dwell_d;
      hum_dwell_q <= hum_dwell_d;
    end
  end

  assign fan_on    = (fan_q == ON);
  assign hum_on    = (hum_q == ON);
  assign t_max     = t_max_q;
  assign h_min     = h_min_q;
  assign agg_valid = agg_valid_q;

endmodule

// File: tb/tb_climate_ctrl.sv
// Directed bench for climate_ctrl: stimulus pushes (cycle, signal, value)
// expectations into a queue that a negedge monitor consumes.
module tb_climate_ctrl;

  localparam int N_CH = 4;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [N_CH-1:0]    sample_valid = '0;
  logic [N_CH*DW-1:0] temperature = '0;
  logic [N_CH*DW-1:0] humidity = '0;
  logic [DW-1:0]      temp_set = 8'd25;
  logic [DW-1:0]      hum_set = 8'd50;
  logic               fan_on, hum_on, agg_valid;
  logic [N_CH-1:0]    fault;
  logic [DW-1:0]      t_max, h_min;

  climate_ctrl #(
    .N_CH(N_CH), .DW(DW), .HYST(2), .DWELL_CYC(16), .STALE_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .temperature(temperature), .humidity(humidity),
    .temp_set(temp_set), .hum_set(hum_set),
    .fan_on(fan_on), .hum_on(hum_on), .fault(fault),
    .t_max(t_max), .h_min(h_min), .agg_valid(agg_valid)
  );

  // clock / reset-relative cycle counter
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // scoreboard
  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  sig;
    logic [15:0] val;
  } exp_t;

  localparam int S_FAN = 0, S_HUM = 1, S_FAULT = 2, S_TMAX = 3, S_HMIN = 4, S_AGG = 5;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string sig_name(input logic [3:0] s);
    case (s)
      4'd0:    return "fan_on";
      4'd1:    return "hum_on";
      4'd2:    return "fault";
      4'd3:    return "t_max";
      4'd4:    return "h_min";
      default: return "agg_valid";
    endcase
  endfunction

  function automatic int actual(input logic [3:0] s);
    case (s)
      4'd0:    return int'(fan_on);
      4'd1:    return int'(hum_on);
      4'd2:    return int'(fault);
      4'd3:    return int'(t_max);
      4'd4:    return int'(h_min);
      default: return int'(agg_valid);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic exp_at(input int c, input int s, input int v);
    exp_t e;
    e.cyc = 32'(c);
    e.sig = s[3:0];
    e.val = v[15:0];
    exp_q.push_back(e);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (int'(exp_q[i].cyc) == cyc) begin
          chk($sformatf("%s@%0d", sig_name(exp_q[i].sig), cyc), actual(exp_q[i].sig), int'(exp_q[i].val));
          exp_q.delete(i);
        end else if (int'(exp_q[i].cyc) < cyc) begin
          chk($sformatf("missed_%s@%0d", sig_name(exp_q[i].sig), int'(exp_q[i].cyc)), 0, 1);
          exp_q.delete(i);
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sample_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic wait_to(input int n);
    for (int k = 0; k < 1000 && cyc != n - 1; k++) @(negedge clk);
    if (cyc != n - 1) chk($sformatf("wait_to_%0d", n), cyc, n - 1);
  endtask

  task automatic set_ch(input int ch, input int t, input int h);
    sample_valid[ch] = 1'b1;
    temperature[ch*DW +: DW] = t[DW-1:0];
    humidity[ch*DW +: DW] = h[DW-1:0];
  endtask

  task automatic step();
    @(negedge clk);
    sample_valid = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #200000;
    chk("watchdog", 1, 0);
    summary();
    $finish;
  end

  initial begin
    // reset values, then asynchronous reset while the fan dwell is running
    do_reset();
    exp_at(1, S_FAN, 0); exp_at(1, S_HUM, 0); exp_at(1, S_FAULT, 0);
    exp_at(1, S_TMAX, 0); exp_at(1, S_HMIN, 0); exp_at(1, S_AGG, 0);
    wait_to(4); set_ch(0, 27, 50); step();
    exp_at(5, S_TMAX, 27); exp_at(6, S_FAN, 1);
    wait_to(9);
    #2 rst_n = 1'b1;
    #1;
    chk("async_fan", int'(fan_on), 0);
    chk("async_hum", int'(hum_on), 0);
    chk("async_fault", int'(fault), 0);
    chk("async_tmax", int'(t_max), 0);
    chk("async_hmin", int'(h_min), 0);
    chk("async_agg", int'(agg_valid), 0);
    @(negedge clk);
    rst_n = 1'b0;

    // fan hysteresis; fan turning on at 6 shows the dwell was cleared by reset
    exp_at(4, S_AGG, 0);
    wait_to(4); set_ch(0, 27, 50); step();
    exp_at(5, S_TMAX, 27); exp_at(5, S_AGG, 1); exp_at(5, S_FAN, 0);
    exp_at(6, S_FAN, 1); exp_at(6, S_HUM, 0);
    wait_to(7); set_ch(0, 24, 50); step();
    exp_at(8, S_TMAX, 24); exp_at(10, S_FAN, 1);
    wait_to(9); set_ch(0, 23, 50); step();
    exp_at(10, S_TMAX, 23); exp_at(22, S_FAN, 1); exp_at(23, S_FAN, 0);
    exp_at(99, S_FAULT, 0); exp_at(100, S_FAULT, 14);
    exp_at(109, S_FAULT, 15); exp_at(109, S_FAN, 0); exp_at(110, S_FAN, 1);
    drain();

    // aggregation across channels
    do_reset();
    wait_to(4);
    set_ch(0, 20, 60); set_ch(1, 30, 45); set_ch(2, 22, 50); set_ch(3, 18, 55); step();
    exp_at(5, S_TMAX, 30); exp_at(5, S_HMIN, 45); exp_at(5, S_AGG, 1); exp_at(5, S_HUM, 0);
    exp_at(6, S_FAN, 1); exp_at(6, S_HUM, 1);
    wait_to(7); set_ch(1, 30, 52); step();
    exp_at(8, S_HMIN, 50); exp_at(24, S_HUM, 1);
    wait_to(25); set_ch(2, 22, 53); step();
    exp_at(26, S_HMIN, 52); exp_at(26, S_HUM, 1); exp_at(27, S_HUM, 0); exp_at(27, S_FAN, 1);
    drain();

    // stale detection, simultaneous refresh, fault recovery
    do_reset();
    wait_to(4);
    set_ch(0, 20, 60); set_ch(1, 30, 60); set_ch(2, 22, 60); set_ch(3, 18, 60); step();
    exp_at(5, S_TMAX, 30); exp_at(6, S_FAN, 1); exp_at(6, S_HUM, 0);
    wait_to(54); set_ch(0, 20, 60); set_ch(2, 22, 60); set_ch(3, 18, 60); step();
    exp_at(103, S_FAULT, 0); exp_at(104, S_FAULT, 2);
    exp_at(104, S_TMAX, 30); exp_at(105, S_TMAX, 22);
    exp_at(105, S_FAN, 1); exp_at(106, S_FAN, 0);
    wait_to(104); set_ch(2, 22, 60); set_ch(3, 18, 60); step();
    exp_at(154, S_FAULT, 2); exp_at(155, S_FAULT, 2);
    wait_to(154); set_ch(0, 20, 60); step();
    exp_at(156, S_FAULT, 2); exp_at(157, S_FAULT, 0);
    wait_to(157); set_ch(1, 30, 60); step();
    exp_at(158, S_TMAX, 30); exp_at(159, S_FAN, 1);
    drain();

    // fail-safe while the fan dwell is at 10, then recovery after dwell
    do_reset();
    wait_to(4); set_ch(0, 20, 60); set_ch(1, 30, 60); step();
    exp_at(6, S_FAN, 1);
    wait_to(12); set_ch(0, 20, 40); step();
    exp_at(14, S_HUM, 1);
    exp_at(105, S_TMAX, 20); exp_at(105, S_AGG, 1); exp_at(106, S_FAN, 0);
    exp_at(112, S_FAULT, 15); exp_at(112, S_FAN, 0); exp_at(112, S_HUM, 1);
    exp_at(113, S_FAN, 1); exp_at(113, S_HUM, 0); exp_at(113, S_AGG, 0);
    exp_at(113, S_TMAX, 20); exp_at(113, S_HMIN, 40);
    wait_to(120); set_ch(0, 20, 40); step();
    exp_at(121, S_AGG, 1); exp_at(129, S_FAN, 1); exp_at(129, S_HUM, 0);
    exp_at(130, S_FAN, 0); exp_at(130, S_HUM, 1);
    drain();

    // threshold saturation at both ends of the setpoint range
    temp_set = 8'd1;
    do_reset();
    wait_to(4); set_ch(0, 5, 50); step();
    exp_at(6, S_FAN, 1);
    wait_to(24); set_ch(0, 1, 50); step();
    exp_at(25, S_TMAX, 1); exp_at(28, S_FAN, 1);
    wait_to(29); set_ch(0, 0, 50); step();
    exp_at(30, S_TMAX, 0); exp_at(30, S_FAN, 1); exp_at(31, S_FAN, 0);
    wait_to(34); temp_set = 8'd254; set_ch(0, 255, 50); step();
    exp_at(35, S_TMAX, 255); exp_at(45, S_FAN, 0); exp_at(50, S_FAN, 0); exp_at(50, S_HUM, 0);
    drain();

    summary();
    $finish;
  end

endmodule
